// File: rtl/riscv_alu_ctrl.sv
// Request/response sequencer for an external combinational ALU: registers one
// operation, captures the result a cycle later into a response FIFO.
// Optional macro RISCV_ALU_CTRL_OPCNT_EN adds a saturating completed-op counter (op_cnt_o).
module riscv_alu_ctrl #(
  parameter int NB_DATA   = 32,
  parameter int NB_OP     = 4,
  parameter int RSP_DEPTH = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [NB_OP-1:0]   req_op_i,
  input  logic [NB_DATA-1:0] req_a_i,
  input  logic [NB_DATA-1:0] req_b_i,
  output logic [NB_OP-1:0]   alu_op_o,
  output logic [NB_DATA-1:0] alu_a_o,
  output logic [NB_DATA-1:0] alu_b_o,
  input  logic [NB_DATA-1:0] alu_p_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [NB_DATA-1:0] rsp_data_o,
  output logic [NB_OP-1:0]   rsp_op_o
`ifdef RISCV_ALU_CTRL_OPCNT_EN
  ,
  output logic [15:0]        op_cnt_o
`endif
);

  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, ready is a pure function of state.
  typedef enum logic {IDLE, EXEC} state_e;

  state_e               state_q, state_d;
  logic [NB_OP-1:0]     op_q, op_d;
  logic [NB_DATA-1:0]   a_q, a_d;
  logic [NB_DATA-1:0]   b_q, b_d;
  logic [NB_DATA-1:0]   data_mem_q [RSP_DEPTH];
  logic [NB_DATA-1:0]   data_mem_d [RSP_DEPTH];
  logic [NB_OP-1:0]     op_mem_q   [RSP_DEPTH];
  logic [NB_OP-1:0]     op_mem_d   [RSP_DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic fifo_empty, fifo_full, accept, push, pop;

  assign fifo_empty  = (cnt_q == '0);
  assign fifo_full   = (cnt_q == CW'(RSP_DEPTH));
  assign req_ready_o = !rst_i && (state_q == IDLE) && !fifo_full;
  assign accept      = req_valid_i && req_ready_o;
  assign push        = (state_q == EXEC);
  assign pop         = !fifo_empty && rsp_ready_i;

  assign alu_op_o    = op_q;
  assign alu_a_o     = a_q;
  assign alu_b_o     = b_q;
  assign rsp_valid_o = !fifo_empty;
  assign rsp_data_o  = fifo_empty ? '0 : data_mem_q[rd_ptr_q];
  assign rsp_op_o    = fifo_empty ? '0 : op_mem_q[rd_ptr_q];

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    data_mem_d = data_mem_q;
    op_mem_d   = op_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q + CW'(push) - CW'(pop);

    case (state_q)
      IDLE: if (accept) begin
        op_d    = req_op_i;
        a_d     = req_a_i;
        b_d     = req_b_i;
        state_d = EXEC;
      end
      EXEC: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A push can never meet a full FIFO: accept was only allowed below depth.
    if (push) begin
      data_mem_d[wr_ptr_q] = alu_p_i;
      op_mem_d[wr_ptr_q]   = op_q;
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        data_mem_q[i] <= '0;
        op_mem_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      data_mem_q <= data_mem_d;
      op_mem_q   <= op_mem_d;
    end
  end

`ifdef RISCV_ALU_CTRL_OPCNT_EN
  logic [15:0] op_cnt_q, op_cnt_d;

  always_comb begin
    op_cnt_d = op_cnt_q;
    if (push && (op_cnt_q != 16'hFFFF)) begin
      op_cnt_d = op_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_cnt_q <= '0;
    end else begin
      op_cnt_q <= op_cnt_d;
    end
  end

  assign op_cnt_o = op_cnt_q;
`endif

endmodule

// File: doc/riscv_alu_ctrl.md
RISCV_ALU_CTRL -- requirements
Module: riscv_alu_ctrl

Interface
REQ-001 The module SHALL have parameter NB_DATA, default 32, giving the operand and result width.
REQ-002 The module SHALL have parameter NB_OP, default 4, giving the ALU opcode width.
REQ-003 The module SHALL have parameter RSP_DEPTH, default 2, giving the response FIFO depth (power of two, >=2).
REQ-004 The module SHALL have port clk_i, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 The module SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-006 The module SHALL have port req_valid_i, input, 1 bit: request valid.
REQ-007 The module SHALL have port req_ready_o, output, 1 bit: request ready.
REQ-008 The module SHALL have port req_op_i, input, NB_OP bits: requested opcode.
REQ-009 The module SHALL have ports req_a_i and req_b_i, inputs, NB_DATA bits each: operands.
REQ-010 The module SHALL have port alu_op_o, output, NB_OP bits: registered opcode to the ALU alu_op_i.
REQ-011 The module SHALL have ports alu_a_o and alu_b_o, outputs, NB_DATA bits each: registered operands to the ALU.
REQ-012 The module SHALL have port alu_p_i, input, NB_DATA bits: combinational ALU result (from alu_p_o).
REQ-013 The module SHALL have port rsp_valid_o, output, 1 bit: response valid.
REQ-014 The module SHALL have port rsp_ready_i, input, 1 bit: response ready.
REQ-015 The module SHALL have port rsp_data_o, output, NB_DATA bits: result at the FIFO head.
REQ-016 The module SHALL have port rsp_op_o, output, NB_OP bits: opcode at the FIFO head.

Function
REQ-017 The FSM SHALL have two states: IDLE and EXEC.
REQ-018 req_ready_o SHALL be high only when the state is IDLE and the FIFO holds fewer than RSP_DEPTH entries.
REQ-019 A request SHALL be accepted on a rising edge where req_valid_i and req_ready_o are both high.
REQ-020 On accept, the module SHALL load req_op_i, req_a_i and req_b_i into alu_op_o, alu_a_o and alu_b_o, and the FSM SHALL go IDLE->EXEC.
REQ-021 In EXEC, on the next edge, the module SHALL push {alu_op_o, alu_p_i} into the FIFO, and the FSM SHALL go EXEC->IDLE.
REQ-022 Latency SHALL be: accept at edge N -> rsp_valid_o high after edge N+1; throughput SHALL be one operation per 2 cycles.
REQ-023 alu_*_o SHALL hold their values outside of an accept edge.
REQ-024 rsp_valid_o SHALL be high exactly when the FIFO is non-empty; when it is empty, rsp_data_o and rsp_op_o SHALL be 0.
REQ-025 A pop SHALL occur on an edge with rsp_valid_o and rsp_ready_i both high.
REQ-026 Simultaneous push and pop SHALL leave the FIFO count unchanged, with order preserved (FIFO).
REQ-027 FIFO read and write pointers SHALL wrap modulo RSP_DEPTH.
REQ-028 The FIFO count SHALL never exceed RSP_DEPTH.
REQ-029 When the FIFO is full, no request SHALL be accepted until a pop.
REQ-030 Request inputs SHALL be ignored while req_ready_o is low.
REQ-031 All arithmetic SHALL be performed in the external ALU; this block SHALL NOT modify data.

Reset
REQ-032 While rst_i is high at a rising edge, the FSM SHALL go to IDLE and the FIFO SHALL be emptied.
REQ-033 While rst_i is high at a rising edge, alu_op_o, alu_a_o, alu_b_o, rsp_data_o and rsp_op_o SHALL be 0, and rsp_valid_o SHALL be 0.
REQ-034 During reset, req_ready_o SHALL be 0; it SHALL be 1 in the first cycle after rst_i deasserts.
REQ-035 Reset during EXEC SHALL discard the in-flight result, with no push.
REQ-036 Reset SHALL override a simultaneous accept or pop.

Configuration
REQ-037 Macro RISCV_ALU_CTRL_OPCNT_EN defined: the module SHALL add output op_cnt_o, 16 bits, counting completed pushes.
REQ-038 op_cnt_o SHALL saturate at 16'hFFFF and SHALL reset to 0.
REQ-039 Macro RISCV_ALU_CTRL_OPCNT_EN undefined: op_cnt_o and its logic SHALL be absent, with all other behaviour identical.

Verification
REQ-040 The bench ALU stub SHALL return alu_p_i = alu_a_o + alu_b_o.
REQ-041 Scenario single op: req op=0, a=5, b=7 accepted at edge N -> rsp_valid_o=1 after N+1, rsp_data_o=12, rsp_op_o=0; pop -> rsp_valid_o=0.
REQ-042 Scenario backpressure: rsp_ready_i=0, three back-to-back requests (1+1, 2+2, 3+3) -> two accepted, req_ready_o=0 with count=2; raise rsp_ready_i -> outputs 2, 4 in order, then third accepted -> 6.
REQ-043 Scenario simultaneous push/pop: FIFO at 1 entry, pop on the same edge as an EXEC push -> count stays 1, data ordering correct.
REQ-044 Scenario reset mid-op: rst_i=1 during EXEC of a=9, b=9 -> no response, all outputs 0, req_ready_o=1 the cycle after release.
REQ-045 Scenario wrap and counter: 10 sequential ops a=i, b=i with rsp_ready_i=1 -> results 0,2,...,18 in order; with the macro defined, op_cnt_o=10.
